// File: rtl/mc_ram_model_if.sv
// Request/response bundle for the multi-channel RAM model. Each channel occupies
// its own slice of every vector.
interface mc_ram_model_if #(
  parameter int NCH    = 2,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 28
);
  logic [NCH-1:0]          ch_re;
  logic [NCH-1:0]          ch_we;
  logic [NCH*ADDR_W-1:0]   ch_addr;
  logic [NCH*DATA_W-1:0]   ch_din;
  logic [NCH*DATA_W/8-1:0] ch_mask;
  logic [NCH*DATA_W-1:0]   ch_dout;
  logic [NCH-1:0]          ch_ready;
  logic [NCH-1:0]          ch_err;

  modport master (
    output ch_re, ch_we, ch_addr, ch_din, ch_mask,
    input  ch_dout, ch_ready, ch_err
  );

  modport slave (
    input  ch_re, ch_we, ch_addr, ch_din, ch_mask,
    output ch_dout, ch_ready, ch_err
  );
endinterface

// File: rtl/mc_ram_model.sv
// Multi-channel byte-masked word RAM. Requests are latched per channel and
// served one at a time in round-robin order, with LAT wait states per access.
module mc_ram_model #(
  parameter int    NCH       = 2,
  parameter int    DATA_W    = 64,
  parameter int    ADDR_W    = 28,
  parameter int    DEPTH     = 256,
  parameter int    LAT       = 0,
  parameter string INIT_FILE = ""
) (
  input logic          clk,
  input logic          rst,
  mc_ram_model_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int GW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [NCH-1:0]      pending;
  logic [NCH-1:0]      ready;
  logic [NCH-1:0]      err;
  logic [NCH*DATA_W-1:0] dout;
  logic [NCH-1:0]      op_we;
  logic [ADDR_W-1:0]   hold_addr [NCH];
  logic [DATA_W-1:0]   hold_din  [NCH];
  logic [MASK_W-1:0]   hold_mask [NCH];
  logic [GW-1:0]       ptr;
  logic [GW-1:0]       grant;
  logic [GW-1:0]       next_grant;
  logic [3:0]          cnt;
  logic [NCH-1:0]      accept;
  logic [ADDR_W-1:0]   cur_addr;
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic                do_access;

  assign bus.ch_ready = ready;
  assign bus.ch_err   = err;
  assign bus.ch_dout  = dout;

  assign accept    = ready & (bus.ch_re | bus.ch_we);
  assign cur_addr  = hold_addr[grant];
  assign in_range  = {1'b0, cur_addr} < DEPTH_LIM;
  assign idx       = cur_addr[IDX_W-1:0];
  assign do_access = (state == BUSY) && (cnt == 4'd0);

  // First pending channel after the last grant, wrapping around.
  always_comb begin
    int cand;
    logic found;
    next_grant = ptr;
    found      = 1'b0;
    cand       = 0;
    for (int k = 1; k <= NCH; k++) begin
      cand = (int'(ptr) + k) % NCH;
      if (!found && pending[cand]) begin
        found      = 1'b1;
        next_grant = GW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (accept[i]) begin
        op_we[i]     <= bus.ch_we[i];
        hold_addr[i] <= bus.ch_addr[i*ADDR_W +: ADDR_W];
        hold_din[i]  <= bus.ch_din[i*DATA_W +: DATA_W];
        hold_mask[i] <= bus.ch_mask[i*MASK_W +: MASK_W];
      end
    end
  end

  // Reset gates the write so an aborted access never reaches the array.
  always_ff @(posedge clk) begin
    if (!rst && do_access && op_we[grant] && in_range) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (hold_mask[grant][b]) mem[idx][8*b +: 8] <= hold_din[grant][8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      ready   <= '1;
      err     <= '0;
      dout    <= '0;
      ptr     <= GW'(NCH - 1);
      grant   <= '0;
      cnt     <= 4'd0;
    end else begin
      err <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (accept[i]) begin
          pending[i] <= 1'b1;
          ready[i]   <= 1'b0;
        end
      end
      case (state)
        IDLE: begin
          if (|pending) begin
            grant <= next_grant;
            ptr   <= next_grant;
            cnt   <= 4'(LAT);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!op_we[grant])
              dout[int'(grant)*DATA_W +: DATA_W] <= in_range ? mem[idx] : '0;
            err[grant]     <= !in_range;
            pending[grant] <= 1'b0;
            ready[grant]   <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
